// File: rtl/bf_program_loader_pkg.sv
// ---------------------------------------------------------------------------
// bf_program_loader_pkg : shared BF opcodes, loader error codes, FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bf_program_loader_pkg;

  localparam logic [3:0] OP_HALT = 4'd0;
  localparam logic [3:0] OP_INCP = 4'd1;
  localparam logic [3:0] OP_DECP = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_DEC  = 4'd4;
  localparam logic [3:0] OP_OUT  = 4'd5;
  localparam logic [3:0] OP_IN   = 4'd6;
  localparam logic [3:0] OP_JMPF = 4'd7;
  localparam logic [3:0] OP_JMPB = 4'd8;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_UNMATCHED = 2'd1;
  localparam logic [1:0] ERR_UNCLOSED  = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_TERM = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/bf_program_loader_char_encoder.sv
// ---------------------------------------------------------------------------
// bf_program_loader_char_encoder : ASCII -> {is_bf, opcode}, combinational
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bf_program_loader_char_encoder
  import bf_program_loader_pkg::*;
(
  input  logic [7:0] char_i,
  output logic       is_bf_o,
  output logic [3:0] op_o
);

  always_comb begin
    is_bf_o = 1'b1;
    op_o    = OP_HALT;
    case (char_i)
      8'h3E:   op_o = OP_INCP;  // '>'
      8'h3C:   op_o = OP_DECP;  // '<'
      8'h2B:   op_o = OP_INC;   // '+'
      8'h2D:   op_o = OP_DEC;   // '-'
      8'h2E:   op_o = OP_OUT;   // '.'
      8'h2C:   op_o = OP_IN;    // ','
      8'h5B:   op_o = OP_JMPF;  // '['
      8'h5D:   op_o = OP_JMPB;  // ']'
      default: is_bf_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/bf_program_loader.sv
// ---------------------------------------------------------------------------
// bf_program_loader : streams ASCII BF source into program memory, appends HALT
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bf_program_loader
  import bf_program_loader_pkg::*;
#(
  parameter int PMAW = 8,
  parameter int OPW  = 4
) (
  input  logic            clock_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [7:0]      in_data_i,
  input  logic            in_valid_i,
  input  logic            in_last_i,
  output logic            in_ready_o,
  output logic [PMAW-1:0] pm_addr_o,
  output logic [OPW-1:0]  pm_data_o,
  output logic            pm_wren_o,
  output logic [PMAW:0]   prog_len_o,
  output logic            done_o,
  output logic            error_o,
  output logic [1:0]      error_code_o
);

  localparam logic [PMAW-1:0] PTR_LAST = '1;
  localparam logic [PMAW-1:0] ONE      = {{(PMAW-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [PMAW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PMAW-1:0] depth_q, depth_d;
  logic [PMAW-1:0] pm_addr_q, pm_addr_d;
  logic [OPW-1:0]  pm_data_q, pm_data_d;
  logic            pm_wren_q, pm_wren_d;
  logic [PMAW:0]   prog_len_q, prog_len_d;
  logic [1:0]      err_code_q, err_code_d;

  logic            is_bf;
  logic [3:0]      op_enc;
  logic            beat;

  bf_program_loader_char_encoder u_enc (
    .char_i  (in_data_i),
    .is_bf_o (is_bf),
    .op_o    (op_enc)
  );

  assign in_ready_o = (state_q == ST_LOAD) && !start_i;
  assign beat       = in_valid_i && in_ready_o;

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    depth_d    = depth_q;
    pm_addr_d  = pm_addr_q;
    pm_data_d  = pm_data_q;
    pm_wren_d  = 1'b0;
    prog_len_d = prog_len_q;
    err_code_d = err_code_q;

    if (start_i) begin
      wr_ptr_d   = '0;
      depth_d    = '0;
      prog_len_d = '0;
      err_code_d = ERR_NONE;
      state_d    = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (beat) begin
            if (is_bf && op_enc == OP_JMPB && depth_q == '0) begin
              err_code_d = ERR_UNMATCHED;
              state_d    = ST_ERR;
            end else if (is_bf && wr_ptr_q == PTR_LAST) begin
              // Last slot is kept free so HALT always fits.
              err_code_d = ERR_OVERFLOW;
              state_d    = ST_ERR;
            end else begin
              if (is_bf) begin
                pm_wren_d = 1'b1;
                pm_addr_d = wr_ptr_q;
                pm_data_d = OPW'(op_enc);
                wr_ptr_d  = wr_ptr_q + ONE;
                if (op_enc == OP_JMPF) depth_d = depth_q + ONE;
                else if (op_enc == OP_JMPB) depth_d = depth_q - ONE;
              end
              if (in_last_i) state_d = ST_TERM;
            end
          end
        end
        ST_TERM: begin
          if (depth_q != '0) begin
            err_code_d = ERR_UNCLOSED;
            state_d    = ST_ERR;
          end else begin
            pm_wren_d  = 1'b1;
            pm_addr_d  = wr_ptr_q;
            pm_data_d  = OPW'(OP_HALT);
            prog_len_d = {1'b0, wr_ptr_q} + {1'b0, ONE};
            state_d    = ST_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      depth_q    <= '0;
      pm_addr_q  <= '0;
      pm_data_q  <= '0;
      pm_wren_q  <= 1'b0;
      prog_len_q <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      depth_q    <= depth_d;
      pm_addr_q  <= pm_addr_d;
      pm_data_q  <= pm_data_d;
      pm_wren_q  <= pm_wren_d;
      prog_len_q <= prog_len_d;
      err_code_q <= err_code_d;
    end
  end

  assign pm_addr_o    = pm_addr_q;
  assign pm_data_o    = pm_data_q;
  assign pm_wren_o    = pm_wren_q;
  assign prog_len_o   = prog_len_q;
  assign done_o       = (state_q == ST_DONE);
  assign error_o      = (state_q == ST_ERR);
  assign error_code_o = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_bf_program_loader.sv
// ---------------------------------------------------------------------------
// tb_bf_program_loader : directed vector bench for bf_program_loader
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bf_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, valid, last;
  logic [7:0] ch;

  logic       rdy, wren, done, err;
  logic [7:0] addr;
  logic [3:0] op;
  logic [8:0] plen;
  logic [1:0] code;

  logic       s_rdy, s_wren, s_done, s_err;
  logic [3:0] s_addr;
  logic [3:0] s_op;
  logic [4:0] s_plen;
  logic [1:0] s_code;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bf_program_loader #(.PMAW(8), .OPW(4)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .in_data_i(ch),
    .in_valid_i(valid), .in_last_i(last), .in_ready_o(rdy),
    .pm_addr_o(addr), .pm_data_o(op), .pm_wren_o(wren), .prog_len_o(plen),
    .done_o(done), .error_o(err), .error_code_o(code)
  );

  // Narrow instance so the overflow boundary is reachable quickly.
  bf_program_loader #(.PMAW(4), .OPW(4)) dut_small (
    .clock_i(clk), .reset_i(rst), .start_i(start), .in_data_i(ch),
    .in_valid_i(valid), .in_last_i(last), .in_ready_o(s_rdy),
    .pm_addr_o(s_addr), .pm_data_o(s_op), .pm_wren_o(s_wren), .prog_len_o(s_plen),
    .done_o(s_done), .error_o(s_err), .error_code_o(s_code)
  );

  typedef struct {
    logic       start, valid, last;
    logic [7:0] ch;
    logic       rdy, wren;
    logic [7:0] addr;
    logic [3:0] op;
    logic       done, err;
    logic [1:0] code;
    logic [8:0] plen;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic s, logic [7:0] c, logic v, logic l, logic r, logic w,
                              logic [7:0] a, logic [3:0] o, logic d, logic e,
                              logic [1:0] cd, logic [8:0] pl);
    vec_t t;
    t.start = s; t.ch = c; t.valid = v; t.last = l; t.rdy = r; t.wren = w;
    t.addr = a; t.op = o; t.done = d; t.err = e; t.code = cd; t.plen = pl;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic s, logic [7:0] c, logic v, logic l);
    start = s; ch = c; valid = v; last = l;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 0, 0);
    tick(); tick();
    rst = 1'b0;
    drive(0, 8'h2B, 1, 0);
    #1;
    n_vec++;
    chk("reset_rdy", rdy, 0);
    chk("reset_wren", wren, 0);
    chk("reset_addr", addr, 0);
    chk("reset_data", op, 0);
    chk("reset_plen", plen, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("reset_code", code, 0);
    tick();
    chk("idle_wren", wren, 0);

    // "+[->+<]." : opcodes 3,7,4,1,3,2,8,5 then HALT at 8
    vq.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h2B, 1, 0, 1, 1, 0, 3, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h5B, 1, 0, 1, 1, 1, 7, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h2D, 1, 0, 1, 1, 2, 4, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h3E, 1, 0, 1, 1, 3, 1, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h2B, 1, 0, 1, 1, 4, 3, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h3C, 1, 0, 1, 1, 5, 2, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h5D, 1, 0, 1, 1, 6, 8, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h2E, 1, 1, 1, 1, 7, 5, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8, 0, 1, 0, 0, 9));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9));
    // "a+ \n-" : only '+','-' written, HALT at 2
    vq.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h61, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h2B, 1, 0, 1, 1, 0, 3, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h20, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h0A, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h2D, 1, 1, 1, 1, 1, 4, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 1, 2, 0, 1, 0, 0, 3));
    // "+]" : unmatched ']'
    vq.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h2B, 1, 0, 1, 1, 0, 3, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h5D, 1, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    vq.push_back(mk(0, 8'h2B, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    // "[[]" : unclosed, then "[]" succeeds
    vq.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h5B, 1, 0, 1, 1, 0, 7, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h5B, 1, 0, 1, 1, 1, 7, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h5D, 1, 1, 1, 1, 2, 8, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0));
    vq.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h5B, 1, 0, 1, 1, 0, 7, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h5D, 1, 1, 1, 1, 1, 8, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 1, 2, 0, 1, 0, 0, 3));
    // start with a valid '+' in the same cycle: '+' must not be consumed
    vq.push_back(mk(1, 8'h2B, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h2D, 1, 0, 1, 1, 0, 4, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h2E, 1, 1, 1, 1, 1, 5, 0, 0, 0, 0));
    vq.push_back(mk(0, 8'h00, 0, 0, 0, 1, 2, 0, 1, 0, 0, 3));

    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].ch, vq[i].valid, vq[i].last);
      #1;
      n_vec++;
      chk($sformatf("v%0d_rdy", i), rdy, vq[i].rdy);
      tick();
      chk($sformatf("v%0d_wren", i), wren, vq[i].wren);
      chk($sformatf("v%0d_done", i), done, vq[i].done);
      chk($sformatf("v%0d_err", i), err, vq[i].err);
      chk($sformatf("v%0d_code", i), code, vq[i].code);
      if (vq[i].wren) begin
        chk($sformatf("v%0d_addr", i), addr, vq[i].addr);
        chk($sformatf("v%0d_data", i), op, vq[i].op);
      end
      if (vq[i].done) chk($sformatf("v%0d_plen", i), plen, vq[i].plen);
    end

    // Overflow on the 4-bit instance: 15 writes, 16th '+' errors without a write
    drive(1, 8'h00, 0, 0);
    tick();
    for (int k = 0; k < 16; k++) begin
      drive(0, 8'h2B, 1, 0);
      tick();
      n_vec++;
      if (k < 15) begin
        chk($sformatf("ovf%0d_wren", k), s_wren, 1);
        chk($sformatf("ovf%0d_addr", k), s_addr, k[3:0]);
        chk($sformatf("ovf%0d_data", k), s_op, 3);
      end else begin
        chk("ovf_last_wren", s_wren, 0);
        chk("ovf_err", s_err, 1);
        chk("ovf_code", s_code, 3);
      end
    end
    drive(0, 8'h2B, 1, 0);
    #1;
    chk("ovf_rdy", s_rdy, 0);
    tick();
    n_vec++;
    chk("ovf_nowrite", s_wren, 0);
    chk("ovf_done", s_done, 0);

    // Reset mid-stream drops the pending write and returns to IDLE
    drive(1, 8'h00, 0, 0);
    tick();
    drive(0, 8'h5B, 1, 0);
    tick();
    drive(0, 8'h2B, 1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    chk("rst_wren", wren, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", op, 0);
    chk("rst_rdy", rdy, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    tick();
    chk("rst_idle_wren", wren, 0);

    drive(0, 8'h00, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
